// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential PC fetch with in-order memory requests, response FIFO and branch redirect
module instr_fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_32b_mode,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_addr,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [63:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_mem_rsp_err,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_instr_addr,
  output logic        o_instr_fault,
  input  logic        i_instr_ready,
  output logic        o_stall,
  output logic        err_rsp_unexpected
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, FAULT} state_t;
  state_t state, state_n;
  logic [63:0] fetch_pc, fetch_pc_n, rsp_pc, rsp_pc_n, tgt;
  logic [CW-1:0] count, count_n, outst, outst_n, discard, discard_n;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem_d [DEPTH];
  logic [63:0] mem_a [DEPTH];
  logic mem_f [DEPTH];
  logic accept, rsp_ok, push, pop, unexp;
  function automatic logic [63:0] msk(input logic [63:0] x, input logic m);
    return m ? {32'h0, x[31:0]} : x;
  endfunction
  assign tgt = msk(i_redirect_addr & ~64'h3, i_32b_mode);
  assign o_mem_req_valid = (state == RUN) && ({1'b0, count} + {1'b0, outst} < (CW+1)'(DEPTH));
  assign o_mem_req_addr = msk(fetch_pc, i_32b_mode);
  assign accept = o_mem_req_valid & i_mem_req_ready;
  assign unexp = i_mem_rsp_valid && (outst == '0);
  assign rsp_ok = i_mem_rsp_valid && (outst != '0);
  assign push = rsp_ok && (state == RUN) && !i_redirect;
  assign pop = o_instr_valid && i_instr_ready && !i_redirect;
  assign o_instr_valid = count != '0;
  assign o_stall = ~o_instr_valid;
  assign o_instr = o_instr_valid ? mem_d[rd_ptr] : '0;
  assign o_instr_addr = o_instr_valid ? mem_a[rd_ptr] : '0;
  assign o_instr_fault = o_instr_valid && mem_f[rd_ptr];
  assign outst_n = outst + CW'(accept) - CW'(rsp_ok);
  assign count_n = i_redirect ? '0 : count + CW'(push) - CW'(pop);
  assign fetch_pc_n = i_redirect ? tgt : accept ? msk(fetch_pc + 64'd4, i_32b_mode) : fetch_pc;
  assign rsp_pc_n = i_redirect ? tgt : push ? msk(rsp_pc + 64'd4, i_32b_mode) : rsp_pc;
  always_comb begin
    state_n = state;
    discard_n = discard;
    if (i_redirect) begin
      discard_n = outst_n;
      state_n = (outst_n != '0) ? DRAIN : RUN;
    end else if (state == BOOT) begin
      state_n = RUN;
    end else if (push && i_mem_rsp_err) begin
      discard_n = outst_n;
      state_n = FAULT;
    end else if (rsp_ok && state != RUN) begin
      discard_n = discard - CW'(discard != '0);
      state_n = (state == DRAIN && discard == CW'(1)) ? RUN : state;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= BOOT;
      fetch_pc <= '0;
      rsp_pc <= '0;
      count <= '0;
      outst <= '0;
      discard <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      err_rsp_unexpected <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      rsp_pc <= rsp_pc_n;
      count <= count_n;
      outst <= outst_n;
      discard <= discard_n;
      rd_ptr <= i_redirect ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= i_redirect ? '0 : wr_ptr + PW'(push);
      err_rsp_unexpected <= unexp;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_d[wr_ptr] <= i_mem_rsp_data;
      mem_a[wr_ptr] <= rsp_pc;
      mem_f[wr_ptr] <= i_mem_rsp_err;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario bench for instr_fetch_unit with a 1-cycle in-order memory model
module tb_instr_fetch_unit;
  typedef struct packed {logic [63:0] a; logic [31:0] d; logic f;} ent_t;
  logic clk = 1'b0;
  logic rst, mode32, redirect, req_valid, req_ready, rsp_valid, rsp_err;
  logic instr_valid, instr_fault, instr_ready, stall, unexp;
  logic [63:0] redirect_addr, req_addr, instr_addr;
  logic [31:0] rsp_data, instr;
  int cmp = 0;
  int bad = 0;
  int rsp_num, err_idx;
  logic rsp_en;
  logic [63:0] rlog[$];
  logic [63:0] pend[$];
  ent_t ilog[$];
  instr_fetch_unit #(.DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_32b_mode(mode32), .i_redirect(redirect),
    .i_redirect_addr(redirect_addr), .o_mem_req_valid(req_valid), .i_mem_req_ready(req_ready),
    .o_mem_req_addr(req_addr), .i_mem_rsp_valid(rsp_valid), .i_mem_rsp_data(rsp_data),
    .i_mem_rsp_err(rsp_err), .o_instr_valid(instr_valid), .o_instr(instr),
    .o_instr_addr(instr_addr), .o_instr_fault(instr_fault), .i_instr_ready(instr_ready),
    .o_stall(stall), .err_rsp_unexpected(unexp)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] rl(input int i);
    return (i < rlog.size()) ? rlog[i] : 'x;
  endfunction
  function automatic ent_t il(input int i);
    return (i < ilog.size()) ? ilog[i] : 'x;
  endfunction
  task automatic tick();
    ent_t e;
    logic [63:0] a;
    if (req_valid && req_ready) begin
      rlog.push_back(req_addr);
      pend.push_back(req_addr);
    end
    if (instr_valid && instr_ready && !redirect) begin
      e.a = instr_addr;
      e.d = instr;
      e.f = instr_fault;
      ilog.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      rsp_valid = 1'b1;
      rsp_data = 32'hC0DE_0000 | {16'h0, a[15:0]};
      rsp_err = (rsp_num == err_idx);
      rsp_num++;
    end else begin
      rsp_valid = 1'b0;
      rsp_data = '0;
      rsp_err = 1'b0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {mode32, redirect, req_ready, rsp_valid, rsp_err, instr_ready, rsp_en} = '0;
    redirect_addr = '0;
    rsp_data = '0;
    rsp_num = 0;
    err_idx = -1;
    rlog.delete();
    pend.delete();
    ilog.delete();
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    cmp++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    cmp++; if (req_addr !== 64'h0) begin bad++; $display("FAIL reset_req_addr got %h want 0", req_addr); end
    cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_fault !== 1'b0) begin bad++; $display("FAIL reset_instr got v=%b i=%h f=%b want 0", instr_valid, instr, instr_fault); end
    cmp++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got %b want 1", stall); end
    cmp++; if (unexp !== 1'b0) begin bad++; $display("FAIL reset_unexp got %b want 0", unexp); end
    rst = 1'b0;
    cmp++; if (req_valid !== 1'b0) begin bad++; $display("FAIL boot_req_valid got %b want 0", req_valid); end
    tick();
    cmp++; if (req_valid !== 1'b1 || req_addr !== 64'h0) begin bad++; $display("FAIL first_req got v=%b a=%h want 1 0", req_valid, req_addr); end
  endtask
  task automatic test_sequential();
    ent_t e;
    do_reset();
    rst = 1'b0;
    {req_ready, instr_ready, rsp_en} = 3'b111;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      e = il(i);
      cmp++; if (rl(i) !== 64'(4 * i)) begin bad++; $display("FAIL seq_req%0d got %h want %h", i, rl(i), 4 * i); end
      cmp++; if (e.a !== 64'(4 * i) || e.d !== (32'hC0DE_0000 | 32'(4 * i)) || e.f !== 1'b0) begin bad++; $display("FAIL seq_instr%0d got a=%h d=%h f=%b want a=%h", i, e.a, e.d, e.f, 4 * i); end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    rst = 1'b0;
    {req_ready, rsp_en} = 2'b11;
    repeat (12) tick();
    cmp++; if (rlog.size() != 4 || req_valid !== 1'b0) begin bad++; $display("FAIL bp_full got n=%0d v=%b want 4 0", rlog.size(), req_valid); end
    cmp++; if (instr_valid !== 1'b1 || instr_addr !== 64'h0) begin bad++; $display("FAIL bp_head got v=%b a=%h want 1 0", instr_valid, instr_addr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (4) tick();
    cmp++; if (rlog.size() != 5 || rl(4) !== 64'h10 || req_valid !== 1'b0) begin bad++; $display("FAIL bp_refill got n=%0d a=%h v=%b want 5 10 0", rlog.size(), rl(4), req_valid); end
    cmp++; if (instr_addr !== 64'h4) begin bad++; $display("FAIL bp_pop_head got %h want 4", instr_addr); end
  endtask
  task automatic test_redirect();
    ent_t e;
    do_reset();
    rst = 1'b0;
    {req_ready, instr_ready} = 2'b11;
    for (int n = 0; n < 20 && rlog.size() < 3; n++) tick();
    req_ready = 1'b0;
    cmp++; if (rlog.size() != 3) begin bad++; $display("FAIL rd_inflight got %0d want 3", rlog.size()); end
    rlog.delete();
    ilog.delete();
    redirect = 1'b1;
    redirect_addr = 64'h1003;
    tick();
    redirect = 1'b0;
    {req_ready, rsp_en} = 2'b11;
    cmp++; if (instr_valid !== 1'b0 || req_valid !== 1'b0) begin bad++; $display("FAIL rd_drain got iv=%b rv=%b want 0 0", instr_valid, req_valid); end
    repeat (10) tick();
    e = il(0);
    cmp++; if (rl(0) !== 64'h1000 || rl(1) !== 64'h1004) begin bad++; $display("FAIL rd_req got %h %h want 1000 1004", rl(0), rl(1)); end
    cmp++; if (e.a !== 64'h1000 || e.d !== 32'hC0DE_1000) begin bad++; $display("FAIL rd_instr got a=%h d=%h want 1000 c0de1000", e.a, e.d); end
  endtask
  task automatic test_fault();
    ent_t e0, e1;
    do_reset();
    rst = 1'b0;
    {req_ready, instr_ready, rsp_en} = 3'b111;
    err_idx = 1;
    repeat (12) tick();
    e0 = il(0);
    e1 = il(1);
    cmp++; if (e0.a !== 64'h0 || e0.f !== 1'b0) begin bad++; $display("FAIL flt_first got a=%h f=%b want 0 0", e0.a, e0.f); end
    cmp++; if (e1.a !== 64'h4 || e1.d !== 32'hC0DE_0004 || e1.f !== 1'b1) begin bad++; $display("FAIL flt_entry got a=%h d=%h f=%b want 4 c0de0004 1", e1.a, e1.d, e1.f); end
    cmp++; if (ilog.size() != 2 || rlog.size() != 3 || req_valid !== 1'b0) begin bad++; $display("FAIL flt_halt got ni=%0d nr=%0d v=%b want 2 3 0", ilog.size(), rlog.size(), req_valid); end
    rlog.delete();
    redirect = 1'b1;
    redirect_addr = 64'h200;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    cmp++; if (rl(0) !== 64'h200) begin bad++; $display("FAIL flt_resume got %h want 200", rl(0)); end
  endtask
  task automatic test_32b_wrap();
    do_reset();
    mode32 = 1'b1;
    rst = 1'b0;
    {req_ready, instr_ready, rsp_en} = 3'b111;
    redirect = 1'b1;
    redirect_addr = 64'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    cmp++; if (rl(0) !== 64'hFFFF_FFFC || rl(1) !== 64'h0 || rl(2) !== 64'h4) begin bad++; $display("FAIL w32_req got %h %h %h want fffffffc 0 4", rl(0), rl(1), rl(2)); end
    cmp++; if (il(0).a !== 64'hFFFF_FFFC || il(1).a !== 64'h0) begin bad++; $display("FAIL w32_instr got %h %h want fffffffc 0", il(0).a, il(1).a); end
  endtask
  task automatic test_unexpected();
    do_reset();
    rst = 1'b0;
    {req_ready, rsp_en} = 2'b11;
    for (int n = 0; n < 20 && rlog.size() < 1; n++) tick();
    req_ready = 1'b0;
    repeat (3) tick();
    cmp++; if (instr_valid !== 1'b1 || instr_addr !== 64'h0 || unexp !== 1'b0) begin bad++; $display("FAIL ux_pre got v=%b a=%h u=%b want 1 0 0", instr_valid, instr_addr, unexp); end
    rsp_en = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h0BAD_0BAD;
    tick();
    cmp++; if (unexp !== 1'b1) begin bad++; $display("FAIL ux_pulse got %b want 1", unexp); end
    cmp++; if (instr_valid !== 1'b1 || instr !== 32'hC0DE_0000 || instr_addr !== 64'h0) begin bad++; $display("FAIL ux_fifo got v=%b i=%h a=%h want 1 c0de0000 0", instr_valid, instr, instr_addr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    cmp++; if (unexp !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL ux_clear got u=%b v=%b want 0 0", unexp, instr_valid); end
  endtask
  initial begin
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault();
    test_32b_wrap();
    test_unexpected();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
